// File: rtl/imem_loader_if.sv
// Bundle between the program loader, its byte source and the instruction RAM write port.
// The loader owns the master modport; the byte source / RAM / CPU side uses slave.
interface imem_loader_if #(
    parameter int ADDR_W = 14
);
    logic              start_load;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              cpu_reset;
    logic              loading;
    logic              done;
    logic [ADDR_W:0]   word_count;
    logic              overflow;

    modport master (
        input  start_load, rx_data, rx_valid,
        output wr_en, wr_addr, wr_data, cpu_reset, loading, done, word_count, overflow
    );

    modport slave (
        output start_load, rx_data, rx_valid,
        input  wr_en, wr_addr, wr_data, cpu_reset, loading, done, word_count, overflow
    );
endinterface

// File: rtl/imem_loader.sv
// Serial program loader: packs a big-endian byte stream into 32-bit words, writes them to
// instruction RAM from word 0 upward and holds the CPU in reset until the load completes.
module imem_loader #(
    parameter int ADDR_W  = 14,
    parameter int TIMEOUT = 1000
) (
    input  logic          clock,
    input  logic          reset,
    imem_loader_if.master bus
);
    localparam int                  TIMER_W    = $clog2(TIMEOUT + 1);
    localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(TIMEOUT - 1);
    localparam logic [TIMER_W-1:0]  TIMER_ONE  = TIMER_W'(1);
    localparam logic [ADDR_W:0]     WORD_ONE   = (ADDR_W + 1)'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]         r_state;
    logic [23:0]        r_shift;
    logic [1:0]         r_byte_cnt;
    logic [TIMER_W-1:0] r_timer;
    logic               r_armed;
    logic [ADDR_W:0]    r_word_count;
    logic               r_overflow;
    logic               r_wr_en;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [31:0]        r_wr_data;
    logic               r_cpu_reset;
    logic               r_loading;
    logic               r_done;

    logic [1:0]         w_next_state;
    logic               w_full;
    logic               w_expire;
    logic [31:0]        w_flush_word;

    // The count never exceeds 2^ADDR_W, so its top bit alone marks a full memory.
    assign w_full   = r_word_count[ADDR_W];
    assign w_expire = (r_state == S_LOAD) && r_armed && !bus.rx_valid && (r_timer == TIMER_LAST);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_flush_word = 32'h0;
        case (r_byte_cnt)
            2'd1:    w_flush_word = {r_shift[7:0],  24'h0};
            2'd2:    w_flush_word = {r_shift[15:0], 16'h0};
            2'd3:    w_flush_word = {r_shift[23:0],  8'h0};
            default: w_flush_word = 32'h0;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (bus.start_load) w_next_state = S_LOAD;
            S_LOAD:  if (w_expire) w_next_state = (r_byte_cnt == 2'd0) ? S_DONE : S_FLUSH;
            S_FLUSH: w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_shift      <= '0;
            r_byte_cnt   <= '0;
            r_timer      <= '0;
            r_armed      <= 1'b0;
            r_word_count <= '0;
            r_overflow   <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_cpu_reset  <= 1'b0;
            r_loading    <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            // Status outputs are registered from the next state so they align with r_state.
            r_state     <= w_next_state;
            r_cpu_reset <= (w_next_state != S_IDLE);
            r_loading   <= (w_next_state == S_LOAD) || (w_next_state == S_FLUSH);
            r_done      <= (w_next_state == S_DONE);
            r_wr_en     <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (bus.start_load) begin
                        r_word_count <= '0;
                        r_byte_cnt   <= '0;
                        r_shift      <= '0;
                        r_overflow   <= 1'b0;
                        r_armed      <= 1'b0;
                        r_timer      <= '0;
                    end
                end

                S_LOAD: begin
                    if (bus.rx_valid) begin
                        r_timer <= '0;
                        r_armed <= 1'b1;
                        if (w_full) begin
                            r_overflow <= 1'b1;
                        end else begin
                            r_shift    <= {r_shift[15:0], bus.rx_data};
                            r_byte_cnt <= r_byte_cnt + 2'd1;
                            if (r_byte_cnt == 2'd3) begin
                                r_wr_en      <= 1'b1;
                                r_wr_addr    <= r_word_count[ADDR_W-1:0];
                                r_wr_data    <= {r_shift, bus.rx_data};
                                r_word_count <= r_word_count + WORD_ONE;
                            end
                        end
                    end else if (w_expire) begin
                        // The padded partial word is written while the FSM sits in FLUSH.
                        r_armed    <= 1'b0;
                        r_timer    <= '0;
                        r_byte_cnt <= '0;
                        if ((r_byte_cnt != 2'd0) && !w_full) begin
                            r_wr_en      <= 1'b1;
                            r_wr_addr    <= r_word_count[ADDR_W-1:0];
                            r_wr_data    <= w_flush_word;
                            r_word_count <= r_word_count + WORD_ONE;
                        end
                    end else if (r_armed) begin
                        r_timer <= r_timer + TIMER_ONE;
                    end
                end

                default: begin
                end
            endcase
        end
    end

    assign bus.wr_en      = r_wr_en;
    assign bus.wr_addr    = r_wr_addr;
    assign bus.wr_data    = r_wr_data;
    assign bus.cpu_reset  = r_cpu_reset;
    assign bus.loading    = r_loading;
    assign bus.done       = r_done;
    assign bus.word_count = r_word_count;
    assign bus.overflow   = r_overflow;
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: expected RAM writes are queued as bytes are driven
// and a negedge monitor pops and compares every wr_en pulse.
module tb_imem_loader;
    localparam int ADDR_W  = 2;
    localparam int TIMEOUT = 16;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus();

    imem_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    wr_t exp_q[$];
    wr_t mon_exp;
    int  checks      = 0;
    int  errors      = 0;
    int  done_pulses = 0;

    always @(negedge clock) begin
        if (bus.done === 1'b1) done_pulses++;
        if (bus.wr_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write",
                         bus.wr_addr, bus.wr_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({bus.wr_addr, bus.wr_data} !== mon_exp) begin
                    errors++;
                    $display("FAIL write_compare: got addr=%0d data=%h, expected addr=%0d data=%h",
                             bus.wr_addr, bus.wr_data, mon_exp.addr, mon_exp.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clock);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start_load = 1'b1;
        @(posedge clock);
        #1;
        bus.start_load = 1'b0;
    endtask

    task automatic push_word(input logic [ADDR_W-1:0] addr, input logic [31:0] data);
        wr_t e;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Returns the cycle index (counted from now) at which done is seen, or 0 if not within 100.
    task automatic wait_done(output int n);
        int i;
        n = 0;
        i = 0;
        while (n == 0 && i < 100) begin
            i++;
            @(posedge clock);
            #1;
            if (bus.done === 1'b1) n = i;
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d expected writes never seen, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        checks++;
        if ({bus.wr_en, bus.wr_addr, bus.wr_data} !== '0) begin
            errors++;
            $display("FAIL reset_wr_port: got en=%b addr=%0d data=%h, expected all 0",
                     bus.wr_en, bus.wr_addr, bus.wr_data);
        end
        checks++;
        if ({bus.cpu_reset, bus.loading, bus.done, bus.overflow} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_status: got cpu_reset/loading/done/overflow=%b, expected 0000",
                     {bus.cpu_reset, bus.loading, bus.done, bus.overflow});
        end
        checks++;
        if (bus.word_count !== '0) begin
            errors++;
            $display("FAIL reset_word_count: got %0d, expected 0", bus.word_count);
        end
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_basic();
        int n;
        pulse_start();
        checks++;
        if ({bus.loading, bus.cpu_reset} !== 2'b11) begin
            errors++;
            $display("FAIL basic_enter_load: got loading/cpu_reset=%b, expected 11",
                     {bus.loading, bus.cpu_reset});
        end
        push_word(2'd0, 32'h3C01_0001);
        push_word(2'd1, 32'h3421_0005);
        send_byte(8'h3C); send_byte(8'h01); send_byte(8'h00); send_byte(8'h01);
        checks++;
        if ({bus.wr_en, bus.wr_addr, bus.wr_data} !== {1'b1, 2'd0, 32'h3C01_0001}) begin
            errors++;
            $display("FAIL basic_latency: got en=%b addr=%0d data=%h, expected en=1 addr=0 data=3c010001",
                     bus.wr_en, bus.wr_addr, bus.wr_data);
        end
        send_byte(8'h34);
        checks++;
        if (bus.wr_en !== 1'b0) begin
            errors++;
            $display("FAIL basic_single_pulse: got wr_en=%b, expected 0", bus.wr_en);
        end
        send_byte(8'h21); send_byte(8'h00); send_byte(8'h05);
        wait_done(n);
        checks++;
        if (n != TIMEOUT) begin
            errors++;
            $display("FAIL basic_timeout: done after %0d idle cycles, expected %0d", n, TIMEOUT);
        end
        checks++;
        if ({bus.word_count, bus.cpu_reset, bus.loading} !== {3'd2, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL basic_done_status: got count=%0d cpu_reset=%b loading=%b, expected 2 1 0",
                     bus.word_count, bus.cpu_reset, bus.loading);
        end
        tick(1);
        checks++;
        if ({bus.cpu_reset, bus.done} !== 2'b00) begin
            errors++;
            $display("FAIL basic_release: got cpu_reset/done=%b, expected 00", {bus.cpu_reset, bus.done});
        end
        checks++;
        if ({bus.wr_addr, bus.wr_data, bus.word_count} !== {2'd1, 32'h3421_0005, 3'd2}) begin
            errors++;
            $display("FAIL basic_hold: got addr=%0d data=%h count=%0d, expected 1 34210005 2",
                     bus.wr_addr, bus.wr_data, bus.word_count);
        end
        check_drained("basic");
        tick(1);
    endtask

    task automatic test_flush();
        int n;
        pulse_start();
        push_word(2'd0, 32'h1234_5678);
        push_word(2'd1, 32'hAABB_0000);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        send_byte(8'hAA); send_byte(8'hBB);
        wait_done(n);
        checks++;
        if (n != TIMEOUT + 1) begin
            errors++;
            $display("FAIL flush_done_time: done after %0d cycles, expected %0d", n, TIMEOUT + 1);
        end
        checks++;
        if (bus.word_count !== 3'd2) begin
            errors++;
            $display("FAIL flush_word_count: got %0d, expected 2", bus.word_count);
        end
        check_drained("flush");
        tick(2);
    endtask

    task automatic test_expiry_race();
        int n;
        int d0;
        pulse_start();
        d0 = done_pulses;
        tick(3 * TIMEOUT);
        checks++;
        if (bus.loading !== 1'b1 || done_pulses != d0) begin
            errors++;
            $display("FAIL race_no_first_byte: got loading=%b done_pulses=%0d, expected 1 and %0d",
                     bus.loading, done_pulses, d0);
        end
        push_word(2'd0, 32'h1122_3344);
        push_word(2'd1, 32'h5566_7788);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        tick(TIMEOUT - 1);
        send_byte(8'h55);
        checks++;
        if (bus.loading !== 1'b1 || done_pulses != d0) begin
            errors++;
            $display("FAIL race_byte_wins: got loading=%b done_pulses=%0d, expected 1 and %0d",
                     bus.loading, done_pulses, d0);
        end
        send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
        wait_done(n);
        checks++;
        if (n != TIMEOUT || bus.word_count !== 3'd2) begin
            errors++;
            $display("FAIL race_finish: got done after %0d count=%0d, expected %0d and 2",
                     n, bus.word_count, TIMEOUT);
        end
        check_drained("race");
        tick(2);
    endtask

    task automatic test_overflow();
        int n;
        logic [7:0] b;
        logic [31:0] w;
        pulse_start();
        for (int k = 0; k < 16; k++) begin
            b = 8'(k * 17 + 3);
            w = {w[23:0], b};
            if (k % 4 == 3) push_word(2'(k / 4), w);
        end
        for (int k = 0; k < 16; k++) send_byte(8'(k * 17 + 3));
        checks++;
        if ({bus.word_count, bus.overflow} !== {3'd4, 1'b0}) begin
            errors++;
            $display("FAIL overflow_full: got count=%0d overflow=%b, expected 4 0",
                     bus.word_count, bus.overflow);
        end
        for (int k = 16; k < 20; k++) send_byte(8'(k * 17 + 3));
        checks++;
        if ({bus.word_count, bus.overflow} !== {3'd4, 1'b1}) begin
            errors++;
            $display("FAIL overflow_set: got count=%0d overflow=%b, expected 4 1",
                     bus.word_count, bus.overflow);
        end
        wait_done(n);
        checks++;
        if (n != TIMEOUT) begin
            errors++;
            $display("FAIL overflow_done_time: done after %0d cycles, expected %0d", n, TIMEOUT);
        end
        tick(3);
        checks++;
        if ({bus.word_count, bus.overflow, bus.wr_addr} !== {3'd4, 1'b1, 2'd3}) begin
            errors++;
            $display("FAIL overflow_hold: got count=%0d overflow=%b addr=%0d, expected 4 1 3",
                     bus.word_count, bus.overflow, bus.wr_addr);
        end
        check_drained("overflow");
    endtask

    task automatic test_reset_midload();
        int d0;
        pulse_start();
        checks++;
        if (bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL midload_overflow_clear: got %b, expected 0", bus.overflow);
        end
        send_byte(8'hDE); send_byte(8'hAD);
        d0 = done_pulses;
        reset = 1'b1;
        tick(1);
        checks++;
        if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.cpu_reset, bus.loading, bus.done,
             bus.word_count, bus.overflow} !== '0) begin
            errors++;
            $display("FAIL midload_reset_outputs: got en=%b addr=%0d data=%h cpu_reset=%b loading=%b done=%b count=%0d ovf=%b, expected all 0",
                     bus.wr_en, bus.wr_addr, bus.wr_data, bus.cpu_reset, bus.loading, bus.done,
                     bus.word_count, bus.overflow);
        end
        reset = 1'b0;
        tick(2 * TIMEOUT);
        checks++;
        if (bus.loading !== 1'b0 || done_pulses != d0) begin
            errors++;
            $display("FAIL midload_idle_after: got loading=%b done_pulses=%0d, expected 0 and %0d",
                     bus.loading, done_pulses, d0);
        end
        check_drained("midload");
    endtask

    task automatic test_ignored_inputs();
        int n;
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        tick(2);
        checks++;
        if ({bus.loading, bus.cpu_reset, bus.word_count} !== {1'b0, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL ignored_idle_bytes: got loading=%b cpu_reset=%b count=%0d, expected 0 0 0",
                     bus.loading, bus.cpu_reset, bus.word_count);
        end
        pulse_start();
        push_word(2'd0, 32'hA1A2_A3A4);
        push_word(2'd1, 32'hB1B2_B3B4);
        send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3); send_byte(8'hA4);
        send_byte(8'hB1); send_byte(8'hB2);
        pulse_start();
        checks++;
        if ({bus.loading, bus.word_count} !== {1'b1, 3'd1}) begin
            errors++;
            $display("FAIL ignored_start_in_load: got loading=%b count=%0d, expected 1 1",
                     bus.loading, bus.word_count);
        end
        send_byte(8'hB3); send_byte(8'hB4);
        wait_done(n);
        checks++;
        if (n != TIMEOUT || bus.word_count !== 3'd2) begin
            errors++;
            $display("FAIL ignored_finish: got done after %0d count=%0d, expected %0d and 2",
                     n, bus.word_count, TIMEOUT);
        end
        check_drained("ignored");
        tick(2);
    endtask

    initial begin
        bus.start_load = 1'b0;
        bus.rx_data    = 8'h00;
        bus.rx_valid   = 1'b0;
        test_reset();
        test_basic();
        test_flush();
        test_expiry_race();
        test_overflow();
        test_reset_midload();
        test_ignored_inputs();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Serial-to-word program loader that writes into the instruction memory the fetch stage reads from.
- Consumes a byte stream (UART receiver byte strobe) and assembles big-endian 32-bit MIPS instructions.
- Drives the instruction RAM write port at incrementing word addresses from 0.
- Holds the CPU in reset while loading, so the fetch stage restarts at PC 0 on a freshly written program.

Parameters:
- ADDR_W, 14, word-address width of instruction memory (2^14 words = 64 KB).
- TIMEOUT, 1000, idle clock cycles after the last byte that terminate a load.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start_load  input  1  single-cycle request to begin a load.
- rx_data  input  8  received byte.
- rx_valid  input  1  one-cycle strobe qualifying rx_data.
- wr_en  output  1  instruction RAM write enable, one-cycle pulse per word.
- wr_addr  output  ADDR_W  word address for the write (byte address >> 2).
- wr_data  output  32  assembled instruction.
- cpu_reset  output  1  holds the CPU/PC in reset while loading.
- loading  output  1  high in LOAD and FLUSH.
- done  output  1  one-cycle pulse when a load completes.
- word_count  output  ADDR_W+1  words written in the current or last load.
- overflow  output  1  sticky; bytes arrived after memory was full.

Behaviour:
- Reset state: IDLE, all outputs 0, byte_cnt=0, timeout counter=0.
- Reset has priority over every event; reset mid-load abandons the partial word and writes nothing further.
- States are IDLE, LOAD, FLUSH, DONE.
- IDLE:
  - rx_valid is ignored.
  - start_load moves to LOAD next cycle.
  - On entry to LOAD: word_count=0, wr addr pointer=0, byte_cnt=0, overflow cleared, timer disarmed.
- LOAD, byte assembly:
  - Each rx_valid shifts a byte into the shift register, big-endian: first byte lands in [31:24], fourth in [7:0].
  - byte_cnt increments mod 4.
- LOAD, word write:
  - On the rx_valid that completes a word (byte_cnt==3), the next cycle asserts wr_en for exactly one cycle.
  - In that cycle wr_addr=pointer and wr_data=the assembled word.
  - The pointer and word_count increment after the write.
  - Write latency is 1 cycle after the 4th byte strobe.
- Memory full:
  - Once word_count==2^ADDR_W, no further writes occur.
  - Any later rx_valid sets overflow and the byte is discarded.
  - The pointer never wraps.
- Timeout:
  - The timer is armed by the first byte and reloads to 0 on every rx_valid.
  - When it reaches TIMEOUT-1 with no rx_valid, the block leaves LOAD.
  - rx_valid in the same cycle as expiry wins: the timer reloads and the block stays in LOAD.
  - Before the first byte there is no timeout; LOAD waits indefinitely.
- Leaving LOAD:
  - byte_cnt==0 → DONE.
  - byte_cnt!=0 → FLUSH.
- FLUSH:
  - The partial word is zero-padded in its unfilled low bytes (e.g. bytes AA,BB → 0xAABB0000).
  - It is written with a one-cycle wr_en at the current pointer, and word_count increments.
  - If memory is full, there is no write.
  - Then → DONE. rx_valid in FLUSH is ignored.
- DONE: done=1 for one cycle, then → IDLE.
- start_load outside IDLE is ignored.
- cpu_reset and loading:
  - cpu_reset is registered; it is 1 in LOAD, FLUSH and DONE, and 0 in IDLE.
  - The CPU therefore leaves reset the cycle after done, with the PC at 0.
  - loading is 1 in LOAD and FLUSH only.
- Stability: wr_addr and wr_data hold their last values when wr_en=0; word_count and overflow hold after DONE until the next start_load.

Test Plan:
- Reset, then start_load, then bytes 3C,01,00,01, 34,21,00,05 with TIMEOUT=16 → wr_en pulses at addr 0 with 0x3C010001 and at addr 1 with 0x34210005; 16 idle cycles later done pulses; word_count=2; cpu_reset falls the following cycle.
- Six bytes 12,34,56,78,AA,BB, then idle until timeout → second write is 0xAABB0000 at addr 1 via FLUSH; word_count=2.
- rx_valid arrives exactly on the expiry cycle → no exit; the load continues, and a subsequent 4-byte group is written at the next address.
- ADDR_W=2, 20 bytes sent → 4 writes at addr 0..3, then overflow=1; no 5th wr_en and no address wrap.
- reset asserted after 2 bytes of a word → next cycle state IDLE, all outputs 0; no wr_en seen.
- rx_valid in IDLE, and start_load during LOAD → no writes or state change in IDLE; the in-progress load is unaffected and word_count is not cleared.
